// File: rtl/gpu_cmd_pkg.sv
// rtl/gpu_cmd_pkg.sv - shared widths, entry type and direction encoding
package gpu_cmd_pkg;

  localparam int CMD_W_DEF  = 8;
  localparam int DATA_W_DEF = 16;

  localparam logic CMD_DIR_WRITE = 1'b0;
  localparam logic CMD_DIR_READ  = 1'b1;

  typedef struct packed {
    logic [CMD_W_DEF-1:0]  code;
    logic [DATA_W_DEF-1:0] data;
  } cmd_entry_t;

endpackage

// File: rtl/gpu_cmd_scheduler_if.sv
// rtl/gpu_cmd_scheduler_if.sv - host command, execution and status signals
interface gpu_cmd_scheduler_if
  import gpu_cmd_pkg::*;
#(
  parameter int CMD_W    = CMD_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int WQ_DEPTH = 16
);

  localparam int WQ_CW = $clog2(WQ_DEPTH) + 1;

  logic              cmd_strobe;
  logic              cmd_inout;
  logic [CMD_W-1:0]  command;
  logic [DATA_W-1:0] commandData;
  logic              render_active;
  logic              wr_valid;
  logic              wr_ready;
  logic [CMD_W-1:0]  wr_cmd;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [CMD_W-1:0]  rd_cmd;
  logic [DATA_W-1:0] rd_data;
  logic              writes_pending;
  logic [WQ_CW-1:0]  wq_count;
  logic              ovf;
  logic              ovf_clr;

  // scheduler side
  modport slave (
    input  cmd_strobe, cmd_inout, command, commandData, render_active,
           wr_ready, rd_ready, ovf_clr,
    output wr_valid, wr_cmd, wr_data, rd_valid, rd_cmd, rd_data,
           writes_pending, wq_count, ovf
  );

  // host / controller / execution side
  modport master (
    output cmd_strobe, cmd_inout, command, commandData, render_active,
           wr_ready, rd_ready, ovf_clr,
    input  wr_valid, wr_cmd, wr_data, rd_valid, rd_cmd, rd_data,
           writes_pending, wq_count, ovf
  );

endinterface

// File: rtl/gpu_cmd_fifo.sv
// rtl/gpu_cmd_fifo.sv - power-of-two FIFO with registered occupancy count
module gpu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic             empty,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Full/empty come from the count register only, so a pop in the same
  // cycle never frees a slot for a push.
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage array; contents need no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally at DEPTH; count tracks push/pop balance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/gpu_cmd_scheduler.sv
// rtl/gpu_cmd_scheduler.sv - split write/read command queues with render gating
module gpu_cmd_scheduler
  import gpu_cmd_pkg::*;
#(
  parameter int CMD_W       = CMD_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int WQ_DEPTH    = 16,
  parameter int RQ_DEPTH    = 4,
  parameter bit READ_BYPASS = 1'b1
) (
  input logic                 cmd_clk_in,
  input logic                 cmd_rst,
  gpu_cmd_scheduler_if.slave  bus
);

  localparam int EW    = CMD_W + DATA_W;
  localparam int RQ_CW = $clog2(RQ_DEPTH) + 1;

  logic             wq_push, wq_pop, wq_full, wq_empty;
  logic             rq_push, rq_pop, rq_full, rq_empty;
  logic [EW-1:0]    wq_head, rq_head;
  logic [RQ_CW-1:0] rq_count_unused;
  logic             drop;
  logic             wr_valid_i, rd_valid_i;

  assign wq_push = bus.cmd_strobe && (bus.cmd_inout == CMD_DIR_WRITE);
  assign rq_push = bus.cmd_strobe && (bus.cmd_inout == CMD_DIR_READ);
  assign drop    = (wq_push && wq_full) || (rq_push && rq_full);

  gpu_cmd_fifo #(.DEPTH(WQ_DEPTH), .WIDTH(EW)) u_wq (
    .clk(cmd_clk_in), .rst(cmd_rst),
    .push(wq_push), .push_data({bus.command, bus.commandData}), .full(wq_full),
    .pop(wq_pop), .empty(wq_empty), .head(wq_head), .count(bus.wq_count)
  );

  gpu_cmd_fifo #(.DEPTH(RQ_DEPTH), .WIDTH(EW)) u_rq (
    .clk(cmd_clk_in), .rst(cmd_rst),
    .push(rq_push), .push_data({bus.command, bus.commandData}), .full(rq_full),
    .pop(rq_pop), .empty(rq_empty), .head(rq_head), .count(rq_count_unused)
  );

  // Issue gating: writes wait out the render, reads either bypass the held
  // writes during a render or wait for the write queue to drain.
  always_comb begin
    wr_valid_i = !wq_empty && !bus.render_active;
    rd_valid_i = !rq_empty && ((READ_BYPASS && bus.render_active) || wq_empty);
  end

  assign wq_pop             = wr_valid_i && bus.wr_ready;
  assign rq_pop             = rd_valid_i && bus.rd_ready;
  assign bus.wr_valid       = wr_valid_i;
  assign bus.rd_valid       = rd_valid_i;
  // Payloads are forced to zero when not offered so reset shows all-zero outputs.
  assign bus.wr_cmd         = wr_valid_i ? wq_head[EW-1:DATA_W] : '0;
  assign bus.wr_data        = wr_valid_i ? wq_head[DATA_W-1:0]  : '0;
  assign bus.rd_cmd         = rd_valid_i ? rq_head[EW-1:DATA_W] : '0;
  assign bus.rd_data        = rd_valid_i ? rq_head[DATA_W-1:0]  : '0;
  assign bus.writes_pending = !wq_empty;

  // Sticky overflow: a drop wins over a same-cycle clear.
  always_ff @(posedge cmd_clk_in or posedge cmd_rst) begin
    if (cmd_rst)          bus.ovf <= 1'b0;
    else if (drop)        bus.ovf <= 1'b1;
    else if (bus.ovf_clr) bus.ovf <= 1'b0;
  end

endmodule

// File: doc/gpu_cmd_scheduler.md
Name: gpu_cmd_scheduler

Overview:
- Parametrised successor to the GPU command buffer stage.
- Sits between the host command bus decode and the GPU execution units (palette, layer headers, RAM).
- Captures host command strobes into separate write and read queues, each of parametrised depth and width.
- Holds writes while a frame render is active and lets reads bypass them; drains all held writes before the next render may begin.

Parameters:
- CMD_W, 8, command code width
- DATA_W, 16, command data width
- WQ_DEPTH, 16, write queue entries (power of two, >=2)
- RQ_DEPTH, 4, read queue entries (power of two, >=2)
- READ_BYPASS, 1, 1 = reads overtake queued writes during render; 0 = reads always wait for an empty write queue

Ports:
- cmd_clk_in  in  1  sole clock, rising edge
- cmd_rst  in  1  asynchronous active-high reset
- cmd_strobe  in  1  one-cycle pulse: command present
- cmd_inout  in  1  1 = read command, 0 = write command
- command  in  CMD_W  command code
- commandData  in  DATA_W  command data
- render_active  in  1  frame render in progress (from controller)
- wr_valid  out  1  write command offered to execution
- wr_ready  in  1  execution accepts write
- wr_cmd  out  CMD_W  head write code
- wr_data  out  DATA_W  head write data
- rd_valid  out  1  read command offered
- rd_ready  in  1  execution accepts read
- rd_cmd  out  CMD_W  head read code
- rd_data  out  DATA_W  head read data
- writes_pending  out  1  write queue non-empty; controller must not start a render while high
- wq_count  out  log2(WQ_DEPTH)+1  write queue occupancy
- ovf  out  1  sticky: a command was dropped
- ovf_clr  in  1  clears ovf

Behaviour:
- Reset (async, any time): both queues empty; pointers and counts 0; ovf = 0. All outputs 0. An in-flight handshake is abandoned. Memory contents are don't-care.
- Enqueue: on cmd_strobe, {command, commandData} is written to the write queue (cmd_inout = 0) or the read queue (cmd_inout = 1) at the clock edge.
- Drops: a strobe to a queue already holding DEPTH entries is dropped and sets ovf.
  - Full is evaluated on the registered count.
  - A same-cycle dequeue does not make room.
- Sticky flag: ovf_clr and a new drop in the same cycle leave ovf = 1.
- Write issue: wr_valid = (wq_count != 0) && !render_active. This is combinational from the count register, so no write handshake can complete in any cycle where render_active = 1.
  - wr_cmd and wr_data present the queue head, are valid whenever wr_valid = 1, and are stable until handshake.
  - Handshake: wr_valid && wr_ready pops one entry.
- Read issue: rd_valid = (rq non-empty) && ((READ_BYPASS && render_active) || wq_count == 0).
  - Handshake: rd_valid && rd_ready pops one entry.
  - Outside a render, queued writes therefore always drain before any read, giving read-after-write consistency.
- Ordering:
  - Reads issue in arrival order; writes issue in arrival order.
  - Writes may overtake an earlier un-issued read. This is specified behaviour; the host avoids write-after-read to the same target while a read is outstanding.
- Latency: a command strobed at cycle N is offerable at cycle N+1 at the earliest (empty queue, gating satisfied).
- Simultaneous events:
  - Enqueue and dequeue on the same queue in one cycle: count unchanged, both take effect.
  - render_active rising in the same cycle a write is offered: wr_valid drops combinationally, and the entry remains queued.
- writes_pending = (wq_count != 0).
- Pointers wrap modulo DEPTH. Count widths hold the value DEPTH exactly.

Decomposition:
- Package gpu_cmd_pkg holds:
  - CMD_W/DATA_W defaults
  - cmd_entry_t struct {code, data}
  - the cmd_inout encoding constants CMD_DIR_WRITE = 0, CMD_DIR_READ = 1
- Sub-module gpu_cmd_fifo (params DEPTH, WIDTH), instantiated twice:
  - ports: push, full, pop, empty, head, count
  - full computed on the registered count; pop with push allowed
- The top adds the gating logic, the ovf flag, and the drop logic.

Test Plan:
- Reset mid-burst: enqueue 3 writes, assert cmd_rst -> wq_count = 0, wr_valid = 0, ovf = 0 immediately; no pops after release.
- Render hold: render_active = 1, strobe write (0x12, 0xBEEF) then read (0x34, 0x0005), wr_ready = rd_ready = 1 -> rd_valid with 0x34/0x0005 one cycle after strobe; wr_valid stays 0 and writes_pending = 1; drop render_active -> write 0x12/0xBEEF issues next cycle and writes_pending falls after its pop.
- READ_BYPASS = 0 variant: same stimulus -> read issues only after the write pops, one cycle later at the earliest.
- Overflow: render_active = 1, 17 writes with WQ_DEPTH = 16 -> wq_count = 16, ovf = 1, 17th entry absent on drain; ovf_clr clears ovf.
- Backpressure and wrap: render_active = 0, 40 random writes with random wr_ready -> issue order and data match a scoreboard, with no loss when strobes respect full.
- Simultaneous push/pop at count 1: strobe write while the head is popped -> count stays 1 and the new entry becomes head next cycle.
